// File: rtl/i2s_tx.sv
// I2S / left-justified stereo transmitter.
// One free-running 10-bit counter produces every clock, so MCLK, SCK and LRCK
// are bits of a single register and stay phase-locked to each other.
// Both samples are captured once per frame.
// Serial data changes on SCK falling edges, so a DAC that samples on SCK rising
// edges sees stable data.
module i2s_tx #(
  parameter int SDIN_DELAY = 1  // SCK slots from LRCK edge to MSB: 1 = I2S, 0 = left-justified
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mute,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic        audio_sdin,
  output logic        sample_tick
);

  logic [9:0]  cnt_reg;
  logic [15:0] hold_l_reg;
  logic [15:0] hold_r_reg;
  logic        sdin_reg;
  logic        tick_reg;

  logic        frame_end;
  logic        sck_fall;
  logic [15:0] hold_l_next;
  logic [15:0] hold_r_next;
  logic [5:0]  slot_next;
  logic [4:0]  k_off;
  logic        in_word;
  logic [15:0] word_next;
  logic [15:0] word_rev;
  logic        sdin_next;

  assign frame_end = (cnt_reg == 10'd1023);
  assign sck_fall  = (cnt_reg[3:0] == 4'd15);

  // Holding registers take new samples only at the end of a frame.
  always_comb begin
    hold_l_next = hold_l_reg;
    hold_r_next = hold_r_reg;
    if (frame_end) begin
      hold_l_next = mute ? 16'h0000 : audio_left;
      hold_r_next = mute ? 16'h0000 : audio_right;
    end
  end

  // Data for the slot that starts after this SCK falling edge. The word is
  // taken from the *next* holding value so that, at the frame wrap, slot 0
  // can already carry the freshly latched left MSB in left-justified mode.
  // An offset of 16..31, including the wrapped value for k'=0 with a one-slot
  // delay, means the slot lies outside the 16-bit word and carries zero.
  assign slot_next = cnt_reg[9:4] + 6'd1;
  assign k_off     = slot_next[4:0] - 5'(SDIN_DELAY);
  assign in_word   = ~k_off[4];
  assign word_next = slot_next[5] ? hold_r_next : hold_l_next;

  // Bit-reverse the word so offset 0 selects the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rev
      assign word_rev[gi] = word_next[15-gi];
    end
  endgenerate

  assign sdin_next = in_word ? word_rev[k_off[3:0]] : 1'b0;

  // Counter, holding registers, serial data and frame tick.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg    <= 10'd0;
      hold_l_reg <= 16'h0000;
      hold_r_reg <= 16'h0000;
      sdin_reg   <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_reg + 10'd1;
      hold_l_reg <= hold_l_next;
      hold_r_reg <= hold_r_next;
      tick_reg   <= frame_end;
      if (sck_fall) begin
        sdin_reg <= sdin_next;
      end
    end
  end

  assign audio_mclk  = cnt_reg[1];
  assign audio_sck   = cnt_reg[3];
  assign audio_lrck  = cnt_reg[9];
  assign audio_sdin  = sdin_reg;
  assign sample_tick = tick_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: two instances (I2S and left-justified) share
// the same stimulus and are compared every cycle against a frame-level model.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst, en, mute;
  logic [15:0] audio_left, audio_right;
  logic        mclk1, sck1, lrck1, sdin1, tick1;
  logic        mclk0, sck0, lrck0, sdin0, tick0;

  int checks = 0;
  int failures = 0;

  // Reference model state: position in frame and the samples of this frame.
  int          m_cnt;
  logic [15:0] m_l, m_r;
  logic        m_tick;

  // Figures gathered by capture().
  logic [63:0] cap1, cap0;
  int          cap_lr_hi, cap_lr_hi_early, cap_ticks, cap_mclk_rises, cap_sck_rises;

  always #5 clk = ~clk;

  i2s_tx #(.SDIN_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mute(mute),
    .audio_left(audio_left), .audio_right(audio_right),
    .audio_mclk(mclk1), .audio_sck(sck1), .audio_lrck(lrck1),
    .audio_sdin(sdin1), .sample_tick(tick1)
  );

  i2s_tx #(.SDIN_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mute(mute),
    .audio_left(audio_left), .audio_right(audio_right),
    .audio_mclk(mclk0), .audio_sck(sck0), .audio_lrck(lrck0),
    .audio_sdin(sdin0), .sample_tick(tick0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h (model cnt=%0d)", name, act, exp, m_cnt);
    end
  endtask

  // Expected pins {mclk,sck,lrck,sdin,tick} for the current model position.
  function automatic logic [4:0] exp_pins(input int d);
    int          c, s, k;
    logic [15:0] w;
    logic        b;
    c = m_cnt;
    s = c / 16;
    k = s % 32;
    w = (s >= 32) ? m_r : m_l;
    b = 1'b0;
    if (k >= d && k <= d + 15) b = w[15-(k-d)];
    return {c[1], c[3], c[9], b, m_tick};
  endfunction

  // Whole frame as seen at SCK rises, slot 0 first.
  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r, input int d);
    if (d == 1) return {1'b0, l, 15'h0000, 1'b0, r, 15'h0000};
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  // One clock: advance the model with the inputs the DUT sees, then compare.
  task automatic step();
    @(posedge clk);
    if (rst || !en) begin
      m_cnt = 0; m_l = 16'h0; m_r = 16'h0; m_tick = 1'b0;
    end else begin
      m_tick = (m_cnt == 1023);
      if (m_cnt == 1023) begin
        m_l = mute ? 16'h0 : audio_left;
        m_r = mute ? 16'h0 : audio_right;
      end
      m_cnt = (m_cnt + 1) % 1024;
    end
    #1;
    check("pins_i2s", {59'd0, mclk1, sck1, lrck1, sdin1, tick1}, {59'd0, exp_pins(1)});
    check("pins_lj",  {59'd0, mclk0, sck0, lrck0, sdin0, tick0}, {59'd0, exp_pins(0)});
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 1100 && m_cnt != target; i++) step();
    checks++;
    if (m_cnt != target) begin
      failures++;
      $display("FAIL run_until_timeout: actual cnt=%0d required=%0d", m_cnt, target);
    end
  endtask

  task automatic next_frame();
    step();
    run_until(0);
  endtask

  // Record one frame from cnt=0; optionally change left/mute at index chg_at.
  task automatic capture(input int chg_at, input logic [15:0] chg_left, input logic chg_mute);
    logic pm, ps;
    check("capture_align", 64'(m_cnt), 64'd0);
    cap1 = '0; cap0 = '0;
    cap_lr_hi = 0; cap_lr_hi_early = 0; cap_ticks = 0; cap_mclk_rises = 0; cap_sck_rises = 0;
    pm = mclk1; ps = sck1;
    for (int i = 0; i < 1024; i++) begin
      if (i == chg_at) begin audio_left = chg_left; mute = chg_mute; end
      if (i % 16 == 8) begin cap1 = {cap1[62:0], sdin1}; cap0 = {cap0[62:0], sdin0}; end
      if (lrck1) cap_lr_hi++;
      if (lrck1 && i < 512) cap_lr_hi_early++;
      if (tick1) cap_ticks++;
      if (mclk1 && !pm) cap_mclk_rises++;
      if (sck1 && !ps) cap_sck_rises++;
      pm = mclk1; ps = sck1;
      step();
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    int         n;
    logic [4:0] exp;  // {mclk, sck, lrck, sdin, tick} of the I2S instance
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst = 1'b1; en = 1'b1; mute = 1'b0;
    audio_left = 16'hA5C3; audio_right = 16'h8001;
    m_cnt = 0; m_l = 16'h0; m_r = 16'h0; m_tick = 1'b0;

    // Reset, clock phases and first data bits of frame 2 (left = A5C3).
    vecs[0]  = '{1'b1, 1'b1, 3,   5'b00000};
    vecs[1]  = '{1'b0, 1'b1, 1,   5'b00000};  // cnt 1
    vecs[2]  = '{1'b0, 1'b1, 2,   5'b10000};  // cnt 3
    vecs[3]  = '{1'b0, 1'b1, 5,   5'b01000};  // cnt 8
    vecs[4]  = '{1'b0, 1'b1, 504, 5'b00100};  // cnt 512
    vecs[5]  = '{1'b0, 1'b1, 511, 5'b11100};  // cnt 1023
    vecs[6]  = '{1'b0, 1'b1, 1,   5'b00001};  // cnt 0, tick
    vecs[7]  = '{1'b0, 1'b1, 16,  5'b00010};  // cnt 16, bit 15
    vecs[8]  = '{1'b0, 1'b1, 16,  5'b00000};  // cnt 32, bit 14
    vecs[9]  = '{1'b0, 1'b1, 16,  5'b00010};  // cnt 48, bit 13
    vecs[10] = '{1'b0, 1'b1, 8,   5'b01010};  // cnt 56
    for (int v = 0; v < 11; v++) begin
      rst = vecs[v].rst; en = vecs[v].en;
      for (int i = 0; i < vecs[v].n; i++) step();
      check($sformatf("vec%0d", v), {59'd0, mclk1, sck1, lrck1, sdin1, tick1}, {59'd0, vecs[v].exp});
    end

    // Whole frame of A5C3 / 8001, plus clock ratios over that frame.
    run_until(0);
    capture(-1, 16'h0, 1'b0);
    check("frame_a5c3_i2s", cap1, exp_frame(16'hA5C3, 16'h8001, 1));
    check("frame_a5c3_lj",  cap0, exp_frame(16'hA5C3, 16'h8001, 0));
    check("lrck_high_cycles", 64'(cap_lr_hi), 64'd512);
    check("lrck_low_first_half", 64'(cap_lr_hi_early), 64'd0);
    check("tick_per_frame", 64'(cap_ticks), 64'd1);
    check("mclk_rises", 64'(cap_mclk_rises), 64'd256);
    check("sck_rises", 64'(cap_sck_rises), 64'd64);

    // Latch stability: change left mid-frame.
    audio_left = 16'h1234; audio_right = 16'(($urandom) & 32'hFFFF);
    next_frame();
    capture(600, 16'h7FFF, 1'b0);
    check("latch_old_i2s", cap1, exp_frame(16'h1234, audio_right, 1));
    check("latch_old_lj",  cap0, exp_frame(16'h1234, audio_right, 0));
    capture(-1, 16'h0, 1'b0);
    check("latch_new_i2s", cap1, exp_frame(16'h7FFF, audio_right, 1));
    check("latch_new_lj",  cap0, exp_frame(16'h7FFF, audio_right, 0));

    // Mute across one latch edge.
    audio_left = 16'hFFFF; audio_right = 16'hFFFF; mute = 1'b1;
    next_frame();
    capture(100, 16'hFFFF, 1'b0);
    check("mute_zero_i2s", cap1, 64'd0);
    check("mute_zero_lj",  cap0, 64'd0);
    capture(-1, 16'h0, 1'b0);
    check("unmute_i2s", cap1, exp_frame(16'hFFFF, 16'hFFFF, 1));
    check("unmute_lj",  cap0, exp_frame(16'hFFFF, 16'hFFFF, 0));

    // Enable dropped at cnt 300, then re-raised.
    run_until(300);
    en = 1'b0;
    step();
    check("en_off_pins", {59'd0, mclk1, sck1, lrck1, sdin1, tick1}, 64'd0);
    for (int i = 0; i < 40; i++) step();
    en = 1'b1;
    capture(-1, 16'h0, 1'b0);
    check("en_first_frame_i2s", cap1, 64'd0);
    check("en_first_frame_lj",  cap0, 64'd0);
    check("en_lrck_low_512", 64'(cap_lr_hi_early), 64'd0);
    check("en_first_no_tick", 64'(cap_ticks), 64'd0);
    capture(-1, 16'h0, 1'b0);
    check("en_second_frame_i2s", cap1, exp_frame(16'hFFFF, 16'hFFFF, 1));

    // Reset mid-frame aborts it; restart sends a zero frame.
    run_until(700);
    rst = 1'b1;
    step();
    check("rst_mid_pins", {59'd0, mclk1, sck1, lrck1, sdin1, tick1}, 64'd0);
    rst = 1'b0;
    capture(-1, 16'h0, 1'b0);
    check("rst_restart_i2s", cap1, 64'd0);
    check("rst_restart_lj",  cap0, 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(7) == 0) audio_left  = 16'($urandom);
      if ($urandom_range(7) == 0) audio_right = 16'($urandom);
      if ($urandom_range(400) == 0) mute = ~mute;
      en  = ($urandom_range(2500) != 0);
      rst = ($urandom_range(4000) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
